// File: rtl/div_sequencer_if.sv
// Handshake bundle between the divide requester/datapath environment and div_sequencer.
// The master side issues requests and hosts the restoring datapath; the slave is the sequencer.
interface div_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic                  is_signed;
    logic [DATA_WIDTH-1:0] dividend;
    logic [DATA_WIDTH-1:0] divisor;
    logic                  busy;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] quotient;
    logic                  div_by_zero;
    logic [DATA_WIDTH-1:0] dp_operand1;
    logic [DATA_WIDTH-1:0] dp_operand2;
    logic                  dp_initialize;
    logic                  dp_load_divident;
    logic                  dp_sh_en;
    logic [DATA_WIDTH-1:0] dp_result;
    logic                  dp_ge;
    logic                  dp_done;

    modport master (
        output start, is_signed, dividend, divisor, dp_result, dp_ge, dp_done,
        input  busy, out_valid, quotient, div_by_zero,
               dp_operand1, dp_operand2, dp_initialize, dp_load_divident, dp_sh_en
    );

    modport slave (
        input  start, is_signed, dividend, divisor, dp_result, dp_ge, dp_done,
        output busy, out_valid, quotient, div_by_zero,
               dp_operand1, dp_operand2, dp_initialize, dp_load_divident, dp_sh_en
    );
endinterface

// File: rtl/div_sequencer.sv
// Sequencer for the multi-cycle restoring divider: operand magnitude capture,
// per-step strobes, sign fix-up and a registered one-cycle result pulse.
module div_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input logic          CLK,
    input logic          RST,
    div_sequencer_if.slave bus
);
    localparam int MSB = DATA_WIDTH - 1;

    typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

    state_t                state, state_nxt;
    logic                  busy_r, vld_r, dz_r, neg_q;
    logic [DATA_WIDTH-1:0] quot_r, op1_r, op2_r;
    logic [DATA_WIDTH-1:0] mag_a, mag_b, q_fix;
    logic                  accept, dz_hit, finish;
    logic                  init_s, load_s, sh_s;

    // Two's-complement negation wraps, so abs(MIN_INT) stays 0x80..0 read as unsigned.
    always_comb begin
        mag_a = (bus.is_signed && bus.dividend[MSB]) ? (~bus.dividend + 1'b1) : bus.dividend;
        mag_b = (bus.is_signed && bus.divisor[MSB])  ? (~bus.divisor + 1'b1)  : bus.divisor;
        q_fix = neg_q ? (~bus.dp_result + 1'b1) : bus.dp_result;
    end

    assign accept = (state == IDLE) && bus.start && (bus.divisor != '0);
    assign dz_hit = (state == IDLE) && bus.start && (bus.divisor == '0);
    assign finish = (state == RUN) && bus.dp_done;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        init_s    = 1'b0;
        load_s    = 1'b0;
        sh_s      = 1'b0;
        case (state)
            IDLE: if (accept) state_nxt = INIT;
            INIT: begin
                init_s    = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                if (bus.dp_done) state_nxt = IDLE;
                else begin
                    load_s = bus.dp_ge;
                    sh_s   = ~bus.dp_ge;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            busy_r <= 1'b0;
            vld_r  <= 1'b0;
            dz_r   <= 1'b0;
            neg_q  <= 1'b0;
            quot_r <= '0;
            op1_r  <= '0;
            op2_r  <= '0;
        end else begin
            vld_r <= 1'b0;
            if (accept) begin
                op1_r  <= mag_a;
                op2_r  <= mag_b;
                neg_q  <= bus.is_signed & (bus.dividend[MSB] ^ bus.divisor[MSB]);
                busy_r <= 1'b1;
            end
            // Divide-by-zero never touches the datapath; answer straight from IDLE.
            if (dz_hit) begin
                quot_r <= '1;
                dz_r   <= 1'b1;
                vld_r  <= 1'b1;
            end
            if (finish) begin
                quot_r <= q_fix;
                dz_r   <= 1'b0;
                vld_r  <= 1'b1;
                busy_r <= 1'b0;
            end
        end
    end

    assign bus.busy             = busy_r;
    assign bus.out_valid        = vld_r;
    assign bus.quotient         = quot_r;
    assign bus.div_by_zero      = dz_r;
    assign bus.dp_operand1      = op1_r;
    assign bus.dp_operand2      = op2_r;
    assign bus.dp_initialize    = init_s;
    assign bus.dp_load_divident = load_s;
    assign bus.dp_sh_en         = sh_s;
endmodule

// File: doc/div_sequencer.md
# div_sequencer

Control front-end for the multi-cycle divide unit. It accepts a divide request from the ALU/execute control, takes the operand magnitudes for signed requests, and drives the restoring-division datapath (initialize, load_divident, sh_en) one step per cycle until the datapath signals done. It then applies the sign fix-up to the datapath quotient and presents a registered result with a one-cycle valid pulse. Divide-by-zero bypasses the datapath entirely.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/quotient width; datapath step count equals DATA_WIDTH.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- is_signed  in  1  1 = two's-complement divide, 0 = unsigned; sampled with start.
- dividend  in  DATA_WIDTH  numerator; sampled with start.
- divisor  in  DATA_WIDTH  denominator; sampled with start.
- busy  out  1  high from the accepting edge until the result edge.
- out_valid  out  1  one-cycle pulse; quotient/div_by_zero valid while high and held after.
- quotient  out  DATA_WIDTH  signed-corrected quotient.
- div_by_zero  out  1  set with out_valid when divisor was 0.
- dp_operand1  out  DATA_WIDTH  registered dividend magnitude to datapath.
- dp_operand2  out  DATA_WIDTH  registered divisor magnitude to datapath.
- dp_initialize  out  1  datapath load strobe.
- dp_load_divident  out  1  subtract-and-shift-1 step.
- dp_sh_en  out  1  shift-0 step.
- dp_result  in  DATA_WIDTH  datapath quotient.
- dp_ge  in  1  datapath dividend >= divisor compare.
- dp_done  in  1  datapath step counter reached DATA_WIDTH.

## Operation
- States: IDLE, INIT, RUN. Reset -> IDLE.
- IDLE, start=1, divisor!=0: register magnitudes (signed: abs; unsigned: as-is; abs(MIN_INT)=0x80000000 unsigned), store neg_q = is_signed & (dividend[MSB] ^ divisor[MSB]), busy<=1, -> INIT.
- IDLE, start=1, divisor==0: quotient<={DATA_WIDTH{1'b1}}, div_by_zero<=1, out_valid<=1, stay IDLE, busy stays 0.
- INIT: dp_initialize=1 for exactly one cycle; -> RUN.
- RUN, dp_done=0: exactly one step strobe per cycle: dp_load_divident=dp_ge, dp_sh_en=~dp_ge (combinational).
- RUN, dp_done=1: no strobe; quotient<= neg_q ? (~dp_result+1) : dp_result, div_by_zero<=0, out_valid<=1, busy<=0, -> IDLE.
- Negation wraps modulo 2^DATA_WIDTH: MIN_INT / -1 yields 0x80000000, no flag.
- start while busy is ignored (not queued).
- dp_initialize, dp_load_divident, dp_sh_en are never high together; all low in IDLE.

## Timing
- Reset values: busy=0, out_valid=0, quotient=0, div_by_zero=0, dp_operand1/2=0, all dp strobes 0, state IDLE.
- Normal divide, start sampled at edge E0: dp_initialize high E0-E1; step strobes E1-E33 (DATA_WIDTH cycles); dp_done high E33-E34; out_valid high E34-E35. Latency 34 edges for DATA_WIDTH=32.
- busy high E0 through E34, low in the out_valid cycle; a new start in the out_valid cycle is accepted.
- Divide-by-zero: out_valid high in the cycle after the sampling edge (latency 1); another start may be accepted in that cycle.
- dp_operand1/2 stable from E0 until the next accepted start.
- Reset mid-operation: all outputs return to reset values asynchronously; no out_valid is produced for the aborted request.

## Test plan
- Unsigned 100/7, datapath model returns 14 -> dp_operand1=100, dp_operand2=7, dp_initialize one cycle, 32 strobes matching dp_ge, out_valid 34 edges after start, quotient=14, div_by_zero=0.
- Signed -7/2 (0xFFFFFFF9, 2), stub dp_result=3 -> dp_operand1=7, quotient=0xFFFFFFFD; signed -8/-2, stub 4 -> quotient=4.
- Signed 0x80000000/0xFFFFFFFF, stub dp_result=0x80000000 -> dp_operand1=0x80000000, dp_operand2=1, quotient=0x80000000, div_by_zero=0.
- divisor=0 (signed and unsigned) -> out_valid next cycle, quotient=0xFFFFFFFF, div_by_zero=1, no dp_initialize or step strobes.
- start pulsed at cycle 10 of a run, then start in the out_valid cycle -> first ignored, second accepted, back-to-back results correct.
- RST low at step 15 -> busy/out_valid/strobes 0 immediately; subsequent 9/3 (stub 3) completes normally with quotient=3.
